// File: rtl/framebuf_stream_reader.sv
// Streams one 1-bit frame from the capture frame RAM as a 2-byte header (A5 5A)
// followed by the pixels packed 8 per byte, first pixel in the MSB.
module framebuf_stream_reader #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_sent,
    output logic              dropped,
    output logic [2:0]        dbg_state_o
);

    localparam longint NPIX = longint'(WIDTH) * longint'(HEIGHT);
    localparam logic [ADDR_W:0] NPIX_W = NPIX[ADDR_W:0];

    generate
        if ((NPIX > (longint'(1) << ADDR_W)) || ((NPIX % 8) != 0)) begin : g_bad_geometry
            $error("framebuf_stream_reader: WIDTH*HEIGHT must fit in 2^ADDR_W and be a multiple of 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_FETCH = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     pix_q;
    logic [ADDR_W:0]     pix_d;
    logic [3:0]          bit_cnt_q;
    logic [7:0]          byte_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [7:0]          out_byte_q;
    logic                out_valid_q;
    logic                frame_sent_q;
    logic                dropped_q;

    // pix_q is one bit wider than the RAM address so a full 2^ADDR_W frame ends without wrapping.
    assign pix_d = pix_q + 1'b1;

    // Stream handshake: a byte transfers on any cycle with out_valid && out_ready; while
    // out_valid is high it stays high and out_byte stays constant until that transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pix_q        <= '0;
            bit_cnt_q    <= '0;
            byte_q       <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            out_byte_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            frame_sent_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            frame_sent_q <= 1'b0;
            dropped_q    <= frame_start && (state_q != S_IDLE);
            rd_en_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q     <= S_HDR0;
                        pix_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_byte_q  <= 8'hA5;
                    end
                end
                S_HDR0: begin
                    if (out_ready) begin
                        state_q    <= S_HDR1;
                        out_byte_q <= 8'h5A;
                    end
                end
                S_HDR1: begin
                    if (out_ready) begin
                        state_q     <= S_FETCH;
                        out_valid_q <= 1'b0;
                        bit_cnt_q   <= '0;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= pix_q[ADDR_W-1:0];
                        pix_q       <= pix_d;
                    end
                end
                S_FETCH: begin
                    // Read k is issued at bit_cnt=k and its data arrives at bit_cnt=k+1.
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q != 4'd0) begin
                        byte_q <= {byte_q[6:0], rd_data};
                    end
                    if (bit_cnt_q < 4'd7) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= pix_q[ADDR_W-1:0];
                        pix_q     <= pix_d;
                    end
                    if (bit_cnt_q == 4'd8) begin
                        state_q     <= S_SEND;
                        out_valid_q <= 1'b1;
                        out_byte_q  <= {byte_q[6:0], rd_data};
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pix_q == NPIX_W) begin
                            state_q      <= S_IDLE;
                            frame_sent_q <= 1'b1;
                        end else begin
                            state_q   <= S_FETCH;
                            bit_cnt_q <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= pix_q[ADDR_W-1:0];
                            pix_q     <= pix_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign out_byte    = out_byte_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_sent  = frame_sent_q;
    assign dropped     = dropped_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/framebuf_stream_reader.md
# framebuf_stream_reader

Reads the 1-bit thresholded frame buffer that the camera capture path writes, packs 8 pixels per byte (MSB first), and streams one frame as header plus packed payload over a byte valid/ready interface. The downstream consumer is the MCU link transmitter.
- Start: a completed-capture pulse.
- Buffer: the read port of the same frame RAM the capture block writes. This block is the reader for that writer.
- Clock domain: system clock domain. `frame_start` is already synchronized into this domain.

## Interface
Parameters:
- `WIDTH`, 320: pixels per line.
- `HEIGHT`, 240: lines per frame.
- `ADDR_W`, 17: frame buffer address width. WIDTH*HEIGHT must be ≤ 2^ADDR_W and divisible by 8 (elaboration-time check).

Ports:
- `clk` in 1: system clock. The only clock.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse, "frame buffer holds a complete frame".
- `rd_en` out 1: frame buffer read enable.
- `rd_addr` out ADDR_W: frame buffer read address (linear, row-major, pixel 0 = top-left).
- `rd_data` in 1: pixel bit. Valid the cycle after `rd_en`.
- `out_byte` out 8: stream data.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `busy` out 1: high in every state except IDLE. The capture side must not start a new frame while it is high.
- `frame_sent` out 1: one-cycle pulse after the last payload byte is accepted.
- `dropped` out 1: one-cycle pulse when a `frame_start` is ignored.

## Operation
- States: IDLE, HDR0, HDR1, FETCH, SEND.
- IDLE:
  - `frame_start`=1: go to HDR0 and clear the pixel address to 0.
- HDR0:
  - Outputs: `out_valid`=1, `out_byte`=0xA5.
  - Accepted (`out_valid`&`out_ready`): go to HDR1.
- HDR1:
  - Outputs: `out_byte`=0x5A.
  - Accepted: go to FETCH with bit_cnt=0.
- FETCH:
  - bit_cnt runs 0..8.
  - bit_cnt<8: `rd_en`=1, `rd_addr`=pixel address, then pixel address +1.
  - bit_cnt≥1: shift `rd_data` into the byte register from the LSB side. The first pixel read ends up in bit 7.
  - bit_cnt=8: go to SEND.
- SEND:
  - Outputs: `out_valid`=1, `out_byte`=assembled byte, held stable until accepted.
  - Accepted, and pixel address = WIDTH*HEIGHT: pulse `frame_sent` and go to IDLE.
  - Accepted otherwise: go to FETCH.
- Arithmetic:
  - Pixel address counter is ADDR_W+1 bits wide, so WIDTH*HEIGHT = 2^ADDR_W does not wrap.
  - `rd_addr` is its low ADDR_W bits.
- Payload: exactly WIDTH*HEIGHT/8 bytes. Total stream: 2 + WIDTH*HEIGHT/8 bytes.
- `frame_start` in any state other than IDLE is ignored and pulses `dropped` the next cycle. This includes the SEND cycle in which the last byte is accepted.
- `rd_en` is never asserted outside FETCH. `rd_addr` holds its last value when `rd_en`=0.
- `out_valid` may not drop before acceptance, and `out_byte` may not change while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: state IDLE; `rd_en`=0, `rd_addr`=0, `out_byte`=0x00, `out_valid`=0, `busy`=0, `frame_sent`=0, `dropped`=0; pixel address 0.
- Reset mid-frame: next cycle, IDLE with all reset values. The frame is abandoned and no `frame_sent` is produced.
- `frame_start` sampled high in IDLE at cycle T: from T+1, `busy`=1, `out_valid`=1, `out_byte`=0xA5.
- FETCH entered at cycle F:
  - Reads issued at F..F+7.
  - Data sampled at the ends of F+1..F+8.
  - SEND with the byte valid at F+9.
- Best-case throughput (`out_ready` always 1): one byte per 10 cycles.
  - Frame duration: 2 + 10·WIDTH·HEIGHT/8 cycles from the first header cycle to the last acceptance.
- `frame_sent` is high the cycle after the last acceptance, coinciding with IDLE and `busy`=0.
- Backpressure stalls only SEND/HDR states. No read is issued while stalled.

## Test plan
Bench parameters: WIDTH=16, HEIGHT=2 (4 payload bytes). Frame buffer model: 1-cycle-latency RAM.
- Basic frame:
  - RAM pattern: pixel i = i[0]. `out_ready`=1. Pulse `frame_start`.
  - Stream = A5 5A 55 55 55 55.
  - `frame_sent` pulses 42 cycles after the first header cycle.
  - `busy` falls with it.
- Bit order:
  - RAM: only pixel 0 and pixel 15 set.
  - Payload = 80 01 00 00.
  - `rd_addr` sequence = 0..31, each address exactly once.
- Backpressure:
  - `out_ready` random, roughly 30% high.
  - Same bytes as the basic frame.
  - `out_byte` stable while valid and not ready.
  - No `rd_en` during stalls.
- Dropped start:
  - Pulse `frame_start` during FETCH and during the final SEND acceptance cycle.
  - `dropped` pulses each time.
  - Stream is unchanged; only one frame is sent.
- Reset mid-frame:
  - Assert `reset` after the 2nd payload byte.
  - All outputs return to reset values the next cycle. No `frame_sent`.
  - A following `frame_start` yields a complete fresh frame starting with A5.
- Back-to-back frames:
  - `frame_start` the cycle after `frame_sent`.
  - Second frame starts the next cycle.
  - Address restarts at 0.
